s2mm_ram_writer: RTL
====================

Name: s2mm_ram_writer

Overview:
- Converts the systolic array's output AXI-Stream into word writes on the simple RAM write port (`wr_en`/`wr_addr`/`wr_data`/`wr_strb`).
- The bench's memory model services this port one cycle after the strobe.
- A command supplies the base byte address and byte count. The block emits one RAM write per accepted beat, masks the tail beat, checks the `tlast` framing and pulses `done`.
- It sits between the array output FIFO and the RAM/DPI memory port.

Parameters:
- AXI_WIDTH, 128, stream/RAM data width in bits; multiple of 8; BPB = AXI_WIDTH/8 bytes per beat.
- ADDR_WIDTH, 32, byte address width.
- LEN_WIDTH, 32, byte-count width.

Ports:
- clk  in  1  clock.
- rstn  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command valid.
- cmd_ready  out  1  command ready; high only in IDLE.
- cmd_addr  in  ADDR_WIDTH  base byte address; low log2(BPB) bits are ignored (treated as 0).
- cmd_bytes  in  LEN_WIDTH  byte count to write.
- s_axis_tdata  in  AXI_WIDTH  stream data.
- s_axis_tkeep  in  BPB  byte enables.
- s_axis_tvalid  in  1  stream valid.
- s_axis_tready  out  1  stream ready.
- s_axis_tlast  in  1  frame end.
- wr_en  out  1  RAM write strobe.
- wr_addr  out  ADDR_WIDTH  RAM byte address, BPB-aligned.
- wr_data  out  AXI_WIDTH  RAM write data.
- wr_strb  out  BPB  RAM byte strobes.
- done  out  1  one-cycle command-complete pulse.
- err  out  1  sticky framing error; cleared on next command accept.

Behaviour:
- Reset values: state=IDLE, cmd_ready=1, s_axis_tready=0, wr_en=0, wr_addr=0, wr_data=0, wr_strb=0, done=0, err=0.
- Reset mid-command abandons it; no further writes occur.
- All outputs are registered.
- States are IDLE, RUN, FIN.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid, latch addr with low bits cleared and set beats_left = ceil(cmd_bytes/BPB).
  - Set last_bytes = cmd_bytes mod BPB, with 0 meaning BPB.
  - Clear err.
  - If cmd_bytes==0, go to FIN (no writes). Otherwise go to RUN.
- RUN:
  - s_axis_tready=1 combinationally from state; the RAM port never back-pressures.
  - Each handshake (tvalid & tready) produces, on the next cycle: wr_en=1, wr_addr=current addr, wr_data=tdata, wr_strb=tkeep & mask.
  - mask is all-ones except on the final beat, where it is the lowest last_bytes bits.
  - After each handshake, addr += BPB (wraps modulo 2^ADDR_WIDTH) and beats_left -= 1.
  - With no handshake, wr_en=0 and the data/addr/strb registers hold.
- Final beat (beats_left==1 at handshake):
  - Go to FIN.
  - If tlast=0, set err; the stream is not drained further (that is the upstream's responsibility).
- Early tlast (tlast=1 with beats_left>1): the beat is written normally, err is set, and the state goes to FIN.
- FIN:
  - s_axis_tready=0.
  - done=1 for exactly this cycle. The final beat's wr_en is issued in this same cycle.
  - Next state is IDLE.
- Latency:
  - Handshake to wr_en is 1 cycle.
  - Final handshake to done is 1 cycle, coincident with the last wr_en.
  - cmd accept with cmd_bytes==0 to done is 1 cycle.
- Throughput: one beat per cycle sustained.
- The beat counter width is LEN_WIDTH.
- cmd_bytes at the maximum value must not overflow the ceil computation; use LEN_WIDTH+1 internally.

Test Plan:
- Aligned full transfer: cmd_addr=0x1000, cmd_bytes=64, 4 beats back-to-back with tlast on beat 4 -> wr_addr 0x1000/0x1010/0x1020/0x1030; wr_strb=0xFFFF each; done on cycle of 4th wr_en; err=0.
- Tail mask: cmd_addr=0x2000, cmd_bytes=37, 3 beats, tkeep=0xFFFF -> 3rd write wr_strb=0x001F at 0x2020; done=1; err=0.
- Random tvalid gaps (~50% valid): cmd_bytes=256 -> exactly 16 wr_en pulses, addresses strictly +16, data matches stream order; RAM image equals y_exp.
- Framing errors: early tlast on beat 2 of a 4-beat command -> 2 writes, done, err=1. Missing tlast on beat 4 -> 4 writes, done, err=1. A following good command clears err.
- Zero length: cmd_bytes=0 -> no wr_en, done one cycle after accept, s_axis_tready never high.
- Reset mid-run: deassert rstn after beat 2 of 8 -> all outputs at reset values immediately; cmd_ready=1 after release; no further writes.

Source files
------------

// File: rtl/s2mm_ram_writer.sv
// s2mm_ram_writer: turns an AXI-Stream of result beats into aligned word writes on a simple RAM port,
// masking the tail beat and flagging tlast framing errors.
module s2mm_ram_writer #(
    parameter int AXI_WIDTH  = 128,
    parameter int ADDR_WIDTH = 32,
    parameter int LEN_WIDTH  = 32,
    localparam int BPB       = AXI_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [LEN_WIDTH-1:0]  cmd_bytes,
    input  logic [AXI_WIDTH-1:0]  s_axis_tdata,
    input  logic [BPB-1:0]        s_axis_tkeep,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic                  s_axis_tlast,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [AXI_WIDTH-1:0]  wr_data,
    output logic [BPB-1:0]        wr_strb,
    output logic                  done,
    output logic                  err
);
    localparam int LB = $clog2(BPB);
    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
    state_t                state_q;
    logic [ADDR_WIDTH-1:0] addr_q, wr_addr_q;
    logic [LEN_WIDTH-1:0]  beats_q, beats_d;
    logic [BPB-1:0]        mask_q, mask_d, wr_strb_q, strb_d;
    logic [AXI_WIDTH-1:0]  wr_data_q;
    logic                  wr_en_q, done_q, err_q, final_d;
    always_comb begin
        // one extra bit keeps the round-up from overflowing at the maximum byte count
        beats_d = LEN_WIDTH'(({1'b0, cmd_bytes} + (LEN_WIDTH + 1)'(BPB - 1)) >> LB);
        for (int i = 0; i < BPB; i++)
            mask_d[i] = (cmd_bytes[LB-1:0] == '0) || (i < int'(cmd_bytes[LB-1:0]));
        final_d = beats_q == LEN_WIDTH'(1);
        strb_d  = s_axis_tkeep & (final_d ? mask_q : '1);
    end
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            beats_q   <= '0;
            mask_q    <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            wr_strb_q <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            wr_en_q <= 1'b0;
            done_q  <= 1'b0;
            case (state_q)
                IDLE: if (cmd_valid) begin
                    addr_q  <= cmd_addr & ~ADDR_WIDTH'(BPB - 1);
                    beats_q <= beats_d;
                    mask_q  <= mask_d;
                    err_q   <= 1'b0;
                    state_q <= (cmd_bytes == '0) ? FIN : RUN;
                    done_q  <= cmd_bytes == '0;
                end
                RUN: if (s_axis_tvalid) begin
                    wr_en_q   <= 1'b1;
                    wr_addr_q <= addr_q;
                    wr_data_q <= s_axis_tdata;
                    wr_strb_q <= strb_d;
                    addr_q    <= addr_q + ADDR_WIDTH'(BPB);
                    beats_q   <= beats_q - LEN_WIDTH'(1);
                    if (final_d || s_axis_tlast) begin
                        state_q <= FIN;
                        done_q  <= 1'b1;
                        err_q   <= err_q | (final_d != s_axis_tlast);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    assign cmd_ready     = state_q == IDLE;
    assign s_axis_tready = state_q == RUN;
    assign wr_en         = wr_en_q;
    assign wr_addr       = wr_addr_q;
    assign wr_data       = wr_data_q;
    assign wr_strb       = wr_strb_q;
    assign done          = done_q;
    assign err           = err_q;
endmodule
